// File: rtl/store_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_write_buffer
// Description : Posted-write FIFO between the CPU store path and data memory.
//               Accepts one store per cycle. A store to the same word as the
//               newest entry is merged into it. Entries drain to memory in
//               allocation order over a req/ack handshake. Buffered full
//               words are forwarded to younger loads.
//               Stores to the uncached MMIO window are never merged. Loads to
//               that window stall until the buffer is empty.
// Ports       : clk/reset                - clock, synchronous active-high reset
//               Store{Valid,Addr,Data,Mask}, StoreReady - CPU store port
//               LoadValid/LoadAddr, FwdHit/FwdData/LoadStall - load snoop
//               MemWr{Req,Addr,Data,Mask}, MemWrAck - memory write port
//               Empty/Count              - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module store_write_buffer #(
    parameter int          DEPTH       = 4,
    parameter logic [15:0] UNCACHED_HI = 16'h1c09
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     StoreValid,
    input  logic [31:0]              StoreAddr,
    input  logic [31:0]              StoreData,
    input  logic [3:0]               StoreMask,
    output logic                     StoreReady,
    input  logic                     LoadValid,
    input  logic [31:0]              LoadAddr,
    output logic                     FwdHit,
    output logic [31:0]              FwdData,
    output logic                     LoadStall,
    output logic                     MemWrReq,
    output logic [31:0]              MemWrAddr,
    output logic [31:0]              MemWrData,
    output logic [3:0]               MemWrMask,
    input  logic                     MemWrAck,
    output logic                     Empty,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    // Entry storage
    logic              r_valid [DEPTH];
    logic [29:0]       r_addr  [DEPTH];
    logic [31:0]       r_data  [DEPTH];
    logic [3:0]        r_mask  [DEPTH];
    logic              r_unc   [DEPTH];

    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_empty;
    logic [c_PTR_W-1:0] w_tail;
    logic               w_pop;
    logic               w_accept;
    logic               w_st_unc;
    logic               w_merge;
    logic               w_push;
    logic [31:0]        w_byte_mask;
    logic               w_unused;

    assign w_empty   = (r_count == '0);
    assign w_tail    = r_wr_ptr - c_PTR_W'(1);
    assign w_pop     = !w_empty && MemWrAck;
    assign w_accept  = StoreValid && StoreReady;
    assign w_st_unc  = (StoreAddr[31:16] == UNCACHED_HI);

    // Merging into the tail is blocked when the tail is the head leaving this
    // cycle; otherwise the merged bytes would be lost with the popped entry.
    assign w_merge   = w_accept && (StoreMask != 4'h0) && !w_empty
                       && (StoreAddr[31:2] == r_addr[w_tail])
                       && !w_st_unc && !r_unc[w_tail]
                       && !((r_count == c_CNT_W'(1)) && w_pop);
    assign w_push    = w_accept && (StoreMask != 4'h0) && !w_merge;

    assign w_byte_mask = {{8{StoreMask[3]}}, {8{StoreMask[2]}},
                          {8{StoreMask[1]}}, {8{StoreMask[0]}}};

    // Word-aligned compares ignore the low address bits.
    assign w_unused  = ^{StoreAddr[1:0], LoadAddr[1:0]};

    // Status and drain outputs
    assign StoreReady = (r_count != c_FULL);
    assign Empty      = w_empty;
    assign Count      = r_count;
    assign MemWrReq   = !w_empty;
    assign MemWrAddr  = w_empty ? 32'h0 : {r_addr[r_rd_ptr], 2'b00};
    assign MemWrData  = w_empty ? 32'h0 : r_data[r_rd_ptr];
    assign MemWrMask  = w_empty ? 4'h0  : r_mask[r_rd_ptr];

    // Load forwarding: walk entries oldest to newest so the youngest match
    // is the one left standing at the end of the loop.
    always_comb begin
        logic               v_match;
        logic [3:0]         v_mmask;
        logic [31:0]        v_mdata;
        logic [c_PTR_W-1:0] v_idx;
        v_match   = 1'b0;
        v_mmask   = 4'h0;
        v_mdata   = 32'h0;
        v_idx     = '0;
        FwdHit    = 1'b0;
        FwdData   = 32'h0;
        LoadStall = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            v_idx = r_rd_ptr + c_PTR_W'(i);
            if ((c_CNT_W'(i) < r_count) && r_valid[v_idx]
                && (r_addr[v_idx] == LoadAddr[31:2])) begin
                v_match = 1'b1;
                v_mmask = r_mask[v_idx];
                v_mdata = r_data[v_idx];
            end
        end
        if (LoadValid) begin
            if ((LoadAddr[31:16] == UNCACHED_HI) && !w_empty) begin
                LoadStall = 1'b1;
            end else if (v_match) begin
                if (v_mmask == 4'hF) begin
                    FwdHit  = 1'b1;
                    FwdData = v_mdata;
                end else begin
                    LoadStall = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_addr[i]  <= 30'h0;
                r_data[i]  <= 32'h0;
                r_mask[i]  <= 4'h0;
                r_unc[i]   <= 1'b0;
            end
        end else begin
            if (w_merge) begin
                r_data[w_tail] <= (r_data[w_tail] & ~w_byte_mask) | (StoreData & w_byte_mask);
                r_mask[w_tail] <= r_mask[w_tail] | StoreMask;
            end
            // A push never targets the head slot: that would require a full
            // buffer, and StoreReady is low then.
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_addr[r_wr_ptr]  <= StoreAddr[31:2];
                r_data[r_wr_ptr]  <= StoreData;
                r_mask[r_wr_ptr]  <= StoreMask;
                r_unc[r_wr_ptr]   <= w_st_unc;
                r_wr_ptr          <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Posted-write buffer between the single-cycle CPU's data-store path and data memory. It is the writer-side counterpart of the instruction cache's read path.
- Accepts one store per cycle, queues it in a small FIFO and drains entries to memory over a req/ack handshake.
- Forwards buffered data to younger loads so the CPU sees program-order memory.
- Stores to the uncached MMIO window (Address[31:16] == 16'h1c09) are never merged. Loads to that window wait until the buffer is empty.

Parameters:
- DEPTH, 4, number of entries; must be a power of two, ≥ 2.
- UNCACHED_HI, 16'h1c09, value of Address[31:16] that marks the uncached/MMIO region.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- StoreValid  in  1  CPU presents a store this cycle
- StoreAddr  in  32  byte address of store; bits [1:0] ignored (word-aligned)
- StoreData  in  32  store data, already lane-aligned
- StoreMask  in  4  byte enables, bit i = byte lane i
- StoreReady  out  1  buffer can accept a store this cycle
- LoadValid  in  1  CPU presents a load this cycle
- LoadAddr  in  32  load byte address (word-aligned compare)
- FwdHit  out  1  load fully satisfied from buffer
- FwdData  out  32  forwarded word, valid when FwdHit
- LoadStall  out  1  CPU must hold the load and retry next cycle
- MemWrReq  out  1  write request to memory
- MemWrAddr  out  32  head entry word address ({addr[31:2],2'b00})
- MemWrData  out  32  head entry data
- MemWrMask  out  4  head entry byte enables
- MemWrAck  in  1  memory accepted the head entry this cycle
- Empty  out  1  no entries held
- Count  out  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Reset state: read/write pointers and Count = 0, all entry valid bits = 0, stored address/data/mask = 0.
  - Outputs after reset: StoreReady=1, Empty=1, MemWrReq=0, MemWrAddr/Data/Mask=0, FwdHit=0, FwdData=0, LoadStall=0.
  - Reset asserted mid-drain discards all entries; no further MemWrReq until a new store is accepted.
- Entry format: valid, word address [31:2], data [31:0], mask [3:0], uncached flag.
- StoreReady = (Count != DEPTH). It does not depend on MemWrAck in the same cycle; no combinational path from ack to ready.
- Store accept: StoreValid && StoreReady at a rising edge.
  - Merge when: buffer non-empty, the word address equals the tail (newest) entry, neither is uncached, and the tail is not also the head being acked this cycle.
  - On merge: bytes with StoreMask=1 overwrite the tail data, tail mask |= StoreMask, Count unchanged.
  - Otherwise a new tail entry is allocated and Count increments.
  - A store with StoreMask=0 is accepted and dropped.
- Drain:
  - MemWrReq = !Empty; MemWrAddr/Data/Mask reflect the head combinationally.
  - The head is held stable while MemWrReq && !MemWrAck.
  - MemWrReq && MemWrAck at an edge pops the head (Count--, read pointer advances, wraps modulo DEPTH).
  - MemWrAck while MemWrReq=0 is ignored.
- Simultaneous push and pop in the same edge: Count unchanged, both pointers advance. When full, only the pop occurs (StoreReady was 0).
- Load forwarding is combinational and evaluated only when LoadValid. Entries are searched newest to oldest for a matching word address.
  - Youngest match with mask 4'hF: FwdHit=1, FwdData=entry data, LoadStall=0.
  - Youngest match with a partial mask: FwdHit=0, LoadStall=1.
  - No match: FwdHit=0, LoadStall=0; the CPU reads memory.
  - LoadAddr[31:16]==UNCACHED_HI && !Empty: LoadStall=1, FwdHit=0, regardless of matches.
  - LoadValid=0: FwdHit=0, LoadStall=0, FwdData=0.
- A store and a load in the same cycle: forwarding sees only entries present before the edge; the incoming store is not forwarded.
- Ordering: entries drain strictly in allocation order. Merging never reorders around an uncached entry.

Test Plan:
- Reset, then store A=0x0000_0100, D=0x1111_2222, M=4'hF → next cycle Count=1, MemWrReq=1, MemWrAddr=0x100, MemWrData=0x1111_2222; ack → Count=0, Empty=1.
- Hold MemWrAck=0 and push 4 stores to 0x100/0x104/0x108/0x10C → StoreReady=0 with Count=4, 5th store not accepted. Ack one → 5th is accepted the following cycle, Count returns to 4, drain order is 0x100, 0x104, 0x108, 0x10C, 5th.
- Ack stalled; store 0x200 D=0x0000_00AA M=4'b0001, then 0x200 D=0x0000_BB00 M=4'b0010 → Count=1, head data 0x0000_BBAA, mask 4'b0011. Load 0x200 → LoadStall=1. Full-word store 0x200 D=0xDEAD_BEEF M=4'hF then load 0x200 → FwdHit=1, FwdData=0xDEAD_BEEF.
- Two stores to MMIO 0x1c09_0000 (M=4'hF) → Count=2, no merge. Load 0x1c09_0004 → LoadStall=1 until both are acked, then 0.
- Buffer with 2 entries, StoreValid and MemWrAck asserted in the same cycle → Count stays 2. Run pointer wrap over ≥ 10 pushes to check FIFO order is preserved.
- Assert reset while Count=3 with MemWrReq=1 → next cycle Count=0, MemWrReq=0, StoreReady=1; a subsequent ack pulse does not change state.
